// File: rtl/jtkcpu_xfrctl.sv
// rtl/jtkcpu_xfrctl.sv - EXG/TFR register transfer sequencer for the KCPU register file
// Optional build macro: JTKCPU_XFR_WIDECHK_EN (reject mixed-width source/destination)
module jtkcpu_xfrctl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        start,
   input  logic [7:0]  op,
   input  logic [7:0]  postbyte,
   output logic [3:0]  rd_sel,
   input  logic [15:0] rd_data,
   output logic [3:0]  wr_sel,
   output logic [15:0] wr_data,
   output logic        wr_we,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        pc_wr
);

   localparam logic [7:0] OP_EXG = 8'h3E;
   localparam logic [7:0] OP_TFR = 8'h3F;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_SRC = 3'd1,
      RD_DST = 3'd2,
      WR_DST = 3'd3,
      WR_SRC = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  op_l, pb_l;
   logic [15:0] tmp0, tmp1;
   logic        ill;
   logic        req_ok;
   logic        wr_act;
   logic [3:0]  src, dst;
   logic        exg;

   function automatic logic is_wide(input logic [3:0] c);
      return c <= 4'h5;
   endfunction

   function automatic logic is_narrow(input logic [3:0] c);
      return c[3:2] == 2'b10;
   endfunction

   // 8-bit values widen with an all-ones high byte; narrow targets keep only the low byte
   function automatic logic [15:0] conv(input logic [15:0] v, input logic [3:0] from_c,
                                        input logic [3:0] to_c);
      if (!is_wide(to_c))
         return {8'h00, v[7:0]};
      else if (is_wide(from_c))
         return v;
      else
         return {8'hFF, v[7:0]};
   endfunction

   assign src = pb_l[7:4];
   assign dst = pb_l[3:0];
   assign exg = (op_l == OP_EXG);

   always_comb begin
      req_ok = (op == OP_EXG || op == OP_TFR)
             && (is_wide(postbyte[7:4]) || is_narrow(postbyte[7:4]))
             && (is_wide(postbyte[3:0]) || is_narrow(postbyte[3:0]));
`ifdef JTKCPU_XFR_WIDECHK_EN
      if (is_wide(postbyte[7:4]) != is_wide(postbyte[3:0]))
         req_ok = 1'b0;
`else
      req_ok = req_ok;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_l  <= 8'h00;
         pb_l  <= 8'h00;
         tmp0  <= 16'h0000;
         tmp1  <= 16'h0000;
         ill   <= 1'b0;
      end else if (cen) begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  op_l <= op;
                  pb_l <= postbyte;
                  ill  <= !req_ok;
               end
            end
            RD_SRC:  tmp0 <= rd_data;
            RD_DST:  tmp1 <= rd_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      rd_sel   = 4'h0;
      wr_sel   = 4'h0;
      wr_data  = 16'h0000;
      wr_act   = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nx = req_ok ? RD_SRC : DONE;
         end
         RD_SRC: begin
            rd_sel   = src;
            state_nx = exg ? RD_DST : WR_DST;
         end
         RD_DST: begin
            rd_sel   = dst;
            state_nx = WR_DST;
         end
         WR_DST: begin
            wr_sel   = dst;
            wr_data  = conv(tmp0, src, dst);
            wr_act   = 1'b1;
            state_nx = exg ? WR_SRC : DONE;
         end
         WR_SRC: begin
            wr_sel   = src;
            wr_data  = conv(tmp1, dst, src);
            wr_act   = 1'b1;
            state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // Reset masks the register-file port at once so an aborted EXG cannot write
      if (rst) begin
         rd_sel  = 4'h0;
         wr_sel  = 4'h0;
         wr_data = 16'h0000;
         wr_act  = 1'b0;
      end
   end

   assign wr_we   = cen & wr_act;
   assign pc_wr   = wr_we & (wr_sel == 4'h5);
   assign busy    = !rst && (state != IDLE);
   assign done    = !rst && (state == DONE);
   assign illegal = done & ill;

endmodule
